axicb_wr_ostdg_ctrl: RTL and testbench

Per-master write-transaction admission controller sitting in front of the master write switch. It counts outstanding write transactions per master: a transaction is counted from AW handshake until its B handshake. It blocks a master's AW requests from reaching the switch arbiter when that master hits its outstanding limit, or when a response timeout has expired for it. This bounds ID-routed B traffic per master and flags masters whose slaves stop responding.

---
 rtl/axicb_pkg.sv | 15 +
 rtl/axicb_ostdg_tracker.sv | 114 +++++++++++
 rtl/axicb_wr_ostdg_ctrl.sv | 53 +++++
 tb/tb_axicb_wr_ostdg_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axicb_pkg.sv
// rtl/axicb_pkg.sv - shared types and helpers for the AXI crossbar write admission control
package axicb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        EXPIRED = 2'd2
    } ostdg_state_t;

    // Width needed to hold an outstanding count in 0..max_ostdg
    function automatic int ostdg_cnt_w(input int max_ostdg);
        return $clog2(max_ostdg + 1);
    endfunction

endpackage

// File: rtl/axicb_ostdg_tracker.sv
// rtl/axicb_ostdg_tracker.sv - one master's outstanding counter, response watchdog and flags
module axicb_ostdg_tracker
    import axicb_pkg::*;
#(
    parameter int MAX_OSTDG      = 4,
    parameter int TIMEOUT_ENABLE = 1,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CNT_W         = ostdg_cnt_w(MAX_OSTDG),
    localparam int TMR_W         = $clog2(TIMEOUT_CYCLES)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             srst,
    input  logic             aw_hs,
    input  logic             b_hs,
    output logic [CNT_W-1:0] cnt,
    output logic             blocked,
    output logic             timeout,
    output logic             unexp_b
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OSTDG);
    // timer_q holds (cycles since last progress - 1), so hitting this value
    // with no B response means the next cycle is TIMEOUT_CYCLES after progress
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    ostdg_state_t     state_q, state_d;
    logic             timeout_q, timeout_d;
    logic             unexp_q, unexp_d;

    // Outstanding count: AW adds, B removes, an unmatched B is flagged and ignored
    always_comb begin
        cnt_d   = cnt_q;
        unexp_d = b_hs && (cnt_q == '0);
        if (aw_hs && !b_hs) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (b_hs && !aw_hs && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (aw_hs && b_hs && (cnt_q == '0)) begin
            cnt_d = CNT_W'(1);
        end
    end

    // Watchdog: time out a master whose outstanding writes see no B progress
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (cnt_d != '0) state_d = WAIT;
            end
            WAIT: begin
                if (cnt_d == '0) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (b_hs) begin
                    timer_d = '0;
                end else if ((TIMEOUT_ENABLE != 0) && (timer_q == TMR_LAST)) begin
                    state_d   = EXPIRED;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            EXPIRED: begin
                if (cnt_d == '0) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
        if (TIMEOUT_ENABLE == 0) begin
            timer_d   = '0;
            timeout_d = 1'b0;
        end
    end

    // State registers; srst and aresetn both return to the power-on state
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q     <= '0;
            timer_q   <= '0;
            state_q   <= IDLE;
            timeout_q <= 1'b0;
            unexp_q   <= 1'b0;
        end else if (srst) begin
            cnt_q     <= '0;
            timer_q   <= '0;
            state_q   <= IDLE;
            timeout_q <= 1'b0;
            unexp_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            state_q   <= state_d;
            timeout_q <= timeout_d;
            unexp_q   <= unexp_d;
        end
    end

    assign cnt     = cnt_q;
    assign blocked = (cnt_q == CNT_MAX) || (state_q == EXPIRED);
    assign timeout = timeout_q;
    assign unexp_b = unexp_q;

endmodule

// File: rtl/axicb_wr_ostdg_ctrl.sv
// rtl/axicb_wr_ostdg_ctrl.sv - per-master write admission controller in front of the write switch
module axicb_wr_ostdg_ctrl
    import axicb_pkg::*;
#(
    parameter int MST_NB         = 4,
    parameter int MAX_OSTDG      = 4,
    parameter int TIMEOUT_ENABLE = 1,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CNT_W         = ostdg_cnt_w(MAX_OSTDG)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    srst,
    input  logic [MST_NB-1:0]       m_awvalid,
    output logic [MST_NB-1:0]       m_awready,
    output logic [MST_NB-1:0]       s_awvalid,
    input  logic [MST_NB-1:0]       s_awready,
    input  logic [MST_NB-1:0]       bvalid,
    input  logic [MST_NB-1:0]       bready,
    output logic [MST_NB*CNT_W-1:0] ostdg_cnt,
    output logic [MST_NB-1:0]       blocked,
    output logic [MST_NB-1:0]       timeout,
    output logic [MST_NB-1:0]       unexp_b
);

    logic [MST_NB-1:0] aw_hs;
    logic [MST_NB-1:0] b_hs;

    // The mask comes only from tracker registers, so no ready/valid loop forms here
    assign s_awvalid = m_awvalid & ~blocked;
    assign m_awready = s_awready & ~blocked;
    assign aw_hs     = s_awvalid & s_awready;
    assign b_hs      = bvalid & bready;

    for (genvar i = 0; i < MST_NB; i++) begin : g_mst
        axicb_ostdg_tracker #(
            .MAX_OSTDG      (MAX_OSTDG),
            .TIMEOUT_ENABLE (TIMEOUT_ENABLE),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_trk (
            .aclk    (aclk),
            .aresetn (aresetn),
            .srst    (srst),
            .aw_hs   (aw_hs[i]),
            .b_hs    (b_hs[i]),
            .cnt     (ostdg_cnt[i*CNT_W +: CNT_W]),
            .blocked (blocked[i]),
            .timeout (timeout[i]),
            .unexp_b (unexp_b[i])
        );
    end

endmodule

// File: tb/tb_axicb_wr_ostdg_ctrl.sv
// tb/tb_axicb_wr_ostdg_ctrl.sv - self-checking bench for axicb_wr_ostdg_ctrl
module tb_axicb_wr_ostdg_ctrl;

    localparam int MST  = 4;
    localparam int MAXO = 4;
    localparam int TC   = 16;
    localparam int CW   = 3;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              srst;
    logic [MST-1:0]    m_awvalid, m_awready, s_awvalid, s_awready;
    logic [MST-1:0]    bvalid, bready;
    logic [MST*CW-1:0] ostdg_cnt;
    logic [MST-1:0]    blocked, timeout, unexp_b;

    axicb_wr_ostdg_ctrl #(
        .MST_NB         (MST),
        .MAX_OSTDG      (MAXO),
        .TIMEOUT_ENABLE (1),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .srst      (srst),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .bvalid    (bvalid),
        .bready    (bready),
        .ostdg_cnt (ostdg_cnt),
        .blocked   (blocked),
        .timeout   (timeout),
        .unexp_b   (unexp_b)
    );

    always #5 aclk = ~aclk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural reference: counts, quiet-cycle age, expiry and flags per master
    int m_cnt[MST];
    int m_quiet[MST];
    bit m_exp[MST];
    bit m_to[MST];
    bit m_ub[MST];

    logic [3:0]  last_sav;
    logic [11:0] last_cnt_pre;

    typedef struct packed {
        logic [3:0]  aw;
        logic [3:0]  sr;
        logic [3:0]  bv;
        logic [3:0]  br;
        logic [3:0]  exp_sav;
        logic [11:0] exp_cnt;
        logic [3:0]  exp_blk;
        logic [3:0]  exp_to;
        logic [3:0]  exp_ub;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_blk();
        logic [3:0] v;
        for (int i = 0; i < MST; i++) v[i] = (m_cnt[i] == MAXO) || m_exp[i];
        return v;
    endfunction

    function automatic logic [11:0] m_cnt_packed();
        logic [11:0] v;
        for (int i = 0; i < MST; i++) v[i*CW +: CW] = m_cnt[i][CW-1:0];
        return v;
    endfunction

    function automatic logic [3:0] m_vec(input int sel);
        logic [3:0] v;
        for (int i = 0; i < MST; i++) v[i] = (sel == 0) ? m_to[i] : m_ub[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MST; i++) begin
            m_cnt[i] = 0; m_quiet[i] = 0; m_exp[i] = 0; m_to[i] = 0; m_ub[i] = 0;
        end
    endtask

    task automatic model_update(input logic [3:0] acc, input logic [3:0] bhs, input bit rst);
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < MST; i++) begin
                int  old;
                bit  prog;
                old       = m_cnt[i];
                m_ub[i]   = bhs[i] && (old == 0);
                m_cnt[i]  = old + int'(acc[i]) - ((bhs[i] && old > 0) ? 1 : 0);
                prog      = bhs[i] || (acc[i] && old == 0);
                if (m_cnt[i] == 0) begin
                    m_exp[i] = 0; m_quiet[i] = 0;
                end else if (!m_exp[i]) begin
                    if (prog) m_quiet[i] = 0;
                    else begin
                        m_quiet[i]++;
                        if (m_quiet[i] >= TC - 1) begin
                            m_exp[i] = 1; m_to[i] = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_regs();
        chk("ostdg_cnt", ostdg_cnt, m_cnt_packed());
        chk("blocked", blocked, m_blk());
        chk("timeout", timeout, m_vec(0));
        chk("unexp_b", unexp_b, m_vec(1));
    endtask

    // One clock: drive at negedge, check pass-through, clock, check registered outputs
    task automatic step(input logic [3:0] aw, input logic [3:0] sr, input logic [3:0] bv,
                        input logic [3:0] br, input bit rst);
        logic [3:0] mb;
        @(negedge aclk);
        m_awvalid = aw; s_awready = sr; bvalid = bv; bready = br; srst = rst;
        #1;
        mb = m_blk();
        last_sav     = s_awvalid;
        last_cnt_pre = ostdg_cnt;
        chk("s_awvalid", s_awvalid, aw & ~mb);
        chk("m_awready", m_awready, sr & ~mb);
        @(posedge aclk);
        model_update(aw & sr & ~mb, bv & br, rst);
        #1;
        check_regs();
    endtask

    task automatic idle_step();
        step(4'b0, 4'b1111, 4'b0, 4'b0, 1'b0);
    endtask

    task automatic pulse_aresetn();
        @(negedge aclk);
        m_awvalid = '0; s_awready = '0; bvalid = '0; bready = '0; srst = 1'b0;
        aresetn = 1'b0;
        #1;
        model_reset();
        chk("arst_cnt", ostdg_cnt, 12'h000);
        chk("arst_blocked", blocked, 4'b0000);
        chk("arst_timeout", timeout, 4'b0000);
        chk("arst_unexp", unexp_b, 4'b0000);
        #2 aresetn = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{4'b0001, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 12'h001, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0001, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 12'h002, 4'b0000, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0001, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 12'h003, 4'b0000, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b0001, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 12'h004, 4'b0001, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0001, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 12'h004, 4'b0001, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b0001, 4'b1111, 4'b0001, 4'b0001, 4'b0000, 12'h003, 4'b0000, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b0001, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 12'h004, 4'b0001, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0010, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 12'h00C, 4'b0001, 4'b0000, 4'b0000};
        tbl[8]  = '{4'b0010, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 12'h014, 4'b0001, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b0010, 4'b1111, 4'b0010, 4'b0010, 4'b0010, 12'h014, 4'b0001, 4'b0000, 4'b0000};
        tbl[10] = '{4'b0000, 4'b1111, 4'b1000, 4'b1000, 4'b0000, 12'h014, 4'b0001, 4'b0000, 4'b1000};
        tbl[11] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 12'h014, 4'b0001, 4'b0000, 4'b0000};
        tbl[12] = '{4'b0000, 4'b1111, 4'b0010, 4'b0000, 4'b0000, 12'h014, 4'b0001, 4'b0000, 4'b0000};

        aresetn = 1'b0; srst = 1'b0;
        m_awvalid = '0; s_awready = '0; bvalid = '0; bready = '0;
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        chk("reset_cnt", ostdg_cnt, 12'h000);
        chk("reset_blocked", blocked, 4'b0000);
        chk("reset_timeout", timeout, 4'b0000);
        chk("reset_unexp", unexp_b, 4'b0000);
        @(negedge aclk);
        aresetn = 1'b1;

        // Directed table: master 0 fills to the limit, master 1 same-cycle AW+B, master 3 stray B
        for (int r = 0; r < 13; r++) begin
            step(tbl[r].aw, tbl[r].sr, tbl[r].bv, tbl[r].br, 1'b0);
            chk($sformatf("tbl%0d_sav", r), last_sav, tbl[r].exp_sav);
            chk($sformatf("tbl%0d_cnt", r), ostdg_cnt, tbl[r].exp_cnt);
            chk($sformatf("tbl%0d_blk", r), blocked, tbl[r].exp_blk);
            chk($sformatf("tbl%0d_to", r), timeout, tbl[r].exp_to);
            chk($sformatf("tbl%0d_ub", r), unexp_b, tbl[r].exp_ub);
        end

        // Counts {3,1,0,2}, cleared by aresetn at once and by srst at the next edge
        pulse_aresetn();
        step(4'b1011, 4'b1111, 4'b0, 4'b0, 1'b0);
        step(4'b1001, 4'b1111, 4'b0, 4'b0, 1'b0);
        step(4'b0001, 4'b1111, 4'b0, 4'b0, 1'b0);
        chk("cnt_3102", ostdg_cnt, 12'h40B);
        pulse_aresetn();
        step(4'b1011, 4'b1111, 4'b0, 4'b0, 1'b0);
        step(4'b1001, 4'b1111, 4'b0, 4'b0, 1'b0);
        step(4'b0001, 4'b1111, 4'b0, 4'b0, 1'b0);
        step(4'b0000, 4'b1111, 4'b0, 4'b0, 1'b1);
        chk("srst_pre_cnt", last_cnt_pre, 12'h40B);
        chk("srst_post_cnt", ostdg_cnt, 12'h000);
        chk("srst_post_blk", blocked, 4'b0000);
        step(4'b0000, 4'b1111, 4'b1000, 4'b1000, 1'b0);
        chk("post_rst_unexp", unexp_b, 4'b1000);

        // Watchdog expiry on master 2 exactly TC cycles after its AW
        pulse_aresetn();
        step(4'b0100, 4'b1111, 4'b0, 4'b0, 1'b0);
        repeat (TC - 2) idle_step();
        chk("to2_before", timeout[2], 1'b0);
        idle_step();
        chk("to2_set", timeout[2], 1'b1);
        chk("to2_blocked", blocked[2], 1'b1);
        step(4'b0100, 4'b1111, 4'b0, 4'b0, 1'b0);
        chk("to2_aw_held", last_sav[2], 1'b0);
        step(4'b0000, 4'b1111, 4'b0100, 4'b0100, 1'b0);
        chk("to2_late_cnt", ostdg_cnt[8:6], 3'd0);
        chk("to2_late_blk", blocked[2], 1'b0);
        chk("to2_sticky", timeout[2], 1'b1);
        step(4'b0100, 4'b1111, 4'b0, 4'b0, 1'b0);
        chk("to2_aw_again", last_sav[2], 1'b1);
        chk("to2_cnt_again", ostdg_cnt[8:6], 3'd1);

        // B every 10 cycles keeps the watchdog quiet
        pulse_aresetn();
        repeat (3) step(4'b0100, 4'b1111, 4'b0, 4'b0, 1'b0);
        for (int p = 0; p < 8; p++) begin
            repeat (9) idle_step();
            step(4'b0100, 4'b1111, 4'b0100, 4'b0100, 1'b0);
        end
        chk("periodic_to", timeout[2], 1'b0);
        chk("periodic_cnt", ostdg_cnt[8:6], 3'd3);

        // Randomized traffic with phases of different B response rates
        pulse_aresetn();
        for (int ph = 0; ph < 10; ph++) begin
            int bprob;
            case (ph % 3)
                0:       bprob = 50;
                1:       bprob = 12;
                default: bprob = 2;
            endcase
            for (int c = 0; c < 200; c++) begin
                logic [3:0] bv;
                for (int i = 0; i < MST; i++) bv[i] = ($urandom_range(0, 99) < bprob);
                step(4'($urandom), 4'($urandom), bv, 4'($urandom) | 4'($urandom),
                     ($urandom_range(0, 299) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
